cafeteira_preparo: RTL and testbench

Brew-sequencing controller for the coffee machine, directly downstream of the serial command decoder. It consumes that stage's one-cycle `pronto` strobe and 2-bit `modo` selection (01 = small, 10 = large). It then runs a timed heat-then-pump cycle on the heater and pump drives. It guards against missing water, supports cancellation, and reports busy, done and error status to the rest of the design.

---
 rtl/cafeteira_preparo.sv | 152 +++++++++++++++
 tb/tb_cafeteira_preparo.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cafeteira_preparo.sv
// cafeteira_preparo: brew sequencer for the coffee machine.
// Takes the decoder's one-cycle command strobe and cup size, runs a timed
// preheat followed by a pump phase, and reports busy/done/fault status.
// Water loss and cancellation abort the cycle one edge after they are seen.
module cafeteira_preparo #(
    parameter int unsigned T_AQUECE  = 250_000_000,
    parameter int unsigned T_PEQUENO = 500_000_000,
    parameter int unsigned T_GRANDE  = 1_000_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pronto,
    input  logic [1:0] modo,
    input  logic       sensor_agua,
    input  logic       cancelar,
    output logic       aquecedor,
    output logic       bomba,
    output logic       ocupado,
    output logic       concluido,
    output logic       erro,
    output logic [2:0] estado_db
);

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        AQUECENDO = 3'd1,
        BOMBEANDO = 3'd2,
        CONCLUIDO = 3'd3,
        ERRO      = 3'd4
    } estado_t;

    localparam logic [1:0] MODO_PEQUENO = 2'b01;
    localparam logic [1:0] MODO_GRANDE  = 2'b10;

    // Terminal counts: each phase ends on the cycle the counter reads T-1.
    localparam logic [31:0] FIM_AQUECE  = 32'(T_AQUECE - 1);
    localparam logic [31:0] FIM_PEQUENO = 32'(T_PEQUENO - 1);
    localparam logic [31:0] FIM_GRANDE  = 32'(T_GRANDE - 1);

    estado_t     estado_q, estado_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  tam_q, tam_d;

    logic        modo_valido;
    logic [31:0] fim_bomba;

    assign modo_valido = (modo == MODO_PEQUENO) || (modo == MODO_GRANDE);
    // Pump length comes from the size latched at start, never from live modo.
    assign fim_bomba   = (tam_q == MODO_GRANDE) ? FIM_GRANDE : FIM_PEQUENO;

    // State, phase counter and latched cup size registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
            cnt_q    <= 32'd0;
            tam_q    <= 2'b00;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            tam_q    <= tam_d;
        end
    end

    // Next-state logic; priority is cancel, then water fault, then timing/start.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        tam_d    = tam_q;
        unique case (estado_q)
            OCIOSO: begin
                // A held cancel also blocks a start in the same cycle.
                if (!cancelar && pronto && modo_valido) begin
                    if (!sensor_agua) begin
                        estado_d = ERRO;
                    end else begin
                        tam_d    = modo;
                        cnt_d    = 32'd0;
                        estado_d = AQUECENDO;
                    end
                end
            end
            AQUECENDO: begin
                if (cancelar) begin
                    cnt_d    = 32'd0;
                    estado_d = OCIOSO;
                end else if (!sensor_agua) begin
                    cnt_d    = 32'd0;
                    estado_d = ERRO;
                end else if (cnt_q == FIM_AQUECE) begin
                    cnt_d    = 32'd0;
                    estado_d = BOMBEANDO;
                end else begin
                    cnt_d    = cnt_q + 32'd1;
                end
            end
            BOMBEANDO: begin
                if (cancelar) begin
                    cnt_d    = 32'd0;
                    estado_d = OCIOSO;
                end else if (!sensor_agua) begin
                    cnt_d    = 32'd0;
                    estado_d = ERRO;
                end else if (cnt_q == fim_bomba) begin
                    cnt_d    = 32'd0;
                    estado_d = CONCLUIDO;
                end else begin
                    cnt_d    = cnt_q + 32'd1;
                end
            end
            CONCLUIDO: begin
                estado_d = OCIOSO;
            end
            ERRO: begin
                // Fault is sticky; only cancel (or reset) releases it.
                if (cancelar) begin
                    cnt_d    = 32'd0;
                    estado_d = OCIOSO;
                end
            end
            default: begin
                cnt_d    = 32'd0;
                estado_d = OCIOSO;
            end
        endcase
    end

    // Moore output decode from the registered state.
    always_comb begin
        aquecedor = 1'b0;
        bomba     = 1'b0;
        ocupado   = 1'b0;
        concluido = 1'b0;
        erro      = 1'b0;
        unique case (estado_q)
            AQUECENDO: begin
                aquecedor = 1'b1;
                ocupado   = 1'b1;
            end
            BOMBEANDO: begin
                aquecedor = 1'b1;
                bomba     = 1'b1;
                ocupado   = 1'b1;
            end
            CONCLUIDO: concluido = 1'b1;
            ERRO:      erro      = 1'b1;
            default:   ;
        endcase
    end

    assign estado_db = estado_q;

endmodule

// File: tb/tb_cafeteira_preparo.sv
// Directed bench for cafeteira_preparo with short phase durations.
// Each step drives inputs for one cycle, queues the outputs expected in the
// cycle after the next rising edge, and checks them once that edge has passed.
module tb_cafeteira_preparo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pronto = 1'b0;
    logic [1:0] modo = 2'b00;
    logic       sensor_agua = 1'b1;
    logic       cancelar = 1'b0;
    logic       aquecedor, bomba, ocupado, concluido, erro;
    logic [2:0] estado_db;

    int checks = 0;
    int failures = 0;
    int passo = 0;

    logic [7:0] sb_q[$];

    cafeteira_preparo #(
        .T_AQUECE (4),
        .T_PEQUENO(3),
        .T_GRANDE (6)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pronto     (pronto),
        .modo       (modo),
        .sensor_agua(sensor_agua),
        .cancelar   (cancelar),
        .aquecedor  (aquecedor),
        .bomba      (bomba),
        .ocupado    (ocupado),
        .concluido  (concluido),
        .erro       (erro),
        .estado_db  (estado_db)
    );

    always #5 clock = ~clock;

    // {aquecedor, bomba, ocupado, concluido, erro, estado_db} for a state code.
    function automatic logic [7:0] esperado(input logic [2:0] st);
        case (st)
            3'd1:    esperado = {5'b10100, st};
            3'd2:    esperado = {5'b11100, st};
            3'd3:    esperado = {5'b00010, st};
            3'd4:    esperado = {5'b00001, st};
            default: esperado = {5'b00000, 3'd0};
        endcase
    endfunction

    task automatic passo_ck(input string tag, input logic p, input logic [1:0] m,
                            input logic s, input logic c, input logic r,
                            input logic [2:0] st_exp);
        logic [7:0] obs;
        logic [7:0] exp_v;
        pronto      = p;
        modo        = m;
        sensor_agua = s;
        cancelar    = c;
        reset       = r;
        sb_q.push_back(esperado(st_exp));
        @(posedge clock);
        #1;
        passo++;
        obs   = {aquecedor, bomba, ocupado, concluido, erro, estado_db};
        exp_v = sb_q.pop_front();
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%b expected=%b", tag, passo, obs, exp_v);
        end
    endtask

    initial begin
        // Reset state
        passo_ck("reset0", 0, 2'b00, 1, 0, 1, 3'd0);
        passo_ck("reset1", 1, 2'b01, 1, 0, 1, 3'd0);
        passo_ck("idle",   0, 2'b00, 1, 0, 0, 3'd0);

        // Small brew, then pronto during CONCLUIDO ignored, then back-to-back start
        passo_ck("peq_start", 1, 2'b01, 1, 0, 0, 3'd1);
        for (int i = 0; i < 3; i++) passo_ck("peq_aq", 0, 2'b00, 1, 0, 0, 3'd1);
        for (int i = 0; i < 3; i++) passo_ck("peq_bo", 0, 2'b00, 1, 0, 0, 3'd2);
        passo_ck("peq_done", 0, 2'b00, 1, 0, 0, 3'd3);
        passo_ck("pronto_in_done", 1, 2'b01, 1, 0, 0, 3'd0);
        passo_ck("b2b_start", 1, 2'b01, 1, 0, 0, 3'd1);
        for (int i = 0; i < 3; i++) passo_ck("b2b_aq", 0, 2'b00, 1, 0, 0, 3'd1);
        for (int i = 0; i < 3; i++) passo_ck("b2b_bo", 0, 2'b00, 1, 0, 0, 3'd2);
        passo_ck("b2b_done", 0, 2'b00, 1, 0, 0, 3'd3);
        passo_ck("b2b_idle", 0, 2'b00, 1, 0, 0, 3'd0);

        // Large brew with a stray small command mid-pump
        passo_ck("gr_start", 1, 2'b10, 1, 0, 0, 3'd1);
        for (int i = 0; i < 3; i++) passo_ck("gr_aq", 0, 2'b00, 1, 0, 0, 3'd1);
        for (int i = 0; i < 6; i++)
            passo_ck("gr_bo", (i == 2), 2'b01, 1, 0, 0, 3'd2);
        passo_ck("gr_done", 0, 2'b00, 1, 0, 0, 3'd3);
        passo_ck("gr_idle", 0, 2'b00, 1, 0, 0, 3'd0);

        // Invalid modes, cancel blocking start, dry start and sticky error
        passo_ck("modo00", 1, 2'b00, 1, 0, 0, 3'd0);
        passo_ck("modo11", 1, 2'b11, 1, 0, 0, 3'd0);
        passo_ck("cancel_blocks", 1, 2'b01, 1, 1, 0, 3'd0);
        passo_ck("dry_start", 1, 2'b01, 0, 0, 0, 3'd4);
        passo_ck("err_hold0", 1, 2'b01, 0, 0, 0, 3'd4);
        passo_ck("err_hold1", 1, 2'b10, 1, 0, 0, 3'd4);
        passo_ck("err_hold2", 0, 2'b00, 1, 0, 0, 3'd4);
        passo_ck("err_cancel", 0, 2'b00, 1, 1, 0, 3'd0);
        passo_ck("err_idle", 0, 2'b00, 1, 0, 0, 3'd0);

        // Water loss at cycle 6 of a large brew
        passo_ck("wl_start", 1, 2'b10, 1, 0, 0, 3'd1);
        for (int i = 0; i < 3; i++) passo_ck("wl_aq", 0, 2'b00, 1, 0, 0, 3'd1);
        passo_ck("wl_bo5", 0, 2'b00, 1, 0, 0, 3'd2);
        passo_ck("wl_bo6", 0, 2'b00, 1, 0, 0, 3'd2);
        passo_ck("wl_fault", 0, 2'b00, 0, 0, 0, 3'd4);
        for (int i = 0; i < 6; i++) passo_ck("wl_hold", 0, 2'b00, (i > 1), 0, 0, 3'd4);
        passo_ck("wl_cancel", 0, 2'b00, 1, 1, 0, 3'd0);

        // Water loss during preheat
        passo_ck("wa_start", 1, 2'b01, 1, 0, 0, 3'd1);
        passo_ck("wa_fault", 0, 2'b00, 0, 0, 0, 3'd4);
        passo_ck("wa_cancel", 0, 2'b00, 1, 1, 0, 3'd0);

        // Cancel during preheat
        passo_ck("cn_start", 1, 2'b01, 1, 0, 0, 3'd1);
        passo_ck("cn_aq2", 0, 2'b00, 1, 0, 0, 3'd1);
        passo_ck("cn_abort", 0, 2'b00, 1, 1, 0, 3'd0);

        // Cancel beats water fault during pump
        passo_ck("cp_start", 1, 2'b01, 1, 0, 0, 3'd1);
        for (int i = 0; i < 3; i++) passo_ck("cp_aq", 0, 2'b00, 1, 0, 0, 3'd1);
        passo_ck("cp_bo", 0, 2'b00, 1, 0, 0, 3'd2);
        passo_ck("cp_abort", 0, 2'b00, 0, 1, 0, 3'd0);

        // Reset with cancel mid-pump, then a fresh small brew times out normally
        passo_ck("rs_start", 1, 2'b10, 1, 0, 0, 3'd1);
        for (int i = 0; i < 3; i++) passo_ck("rs_aq", 0, 2'b00, 1, 0, 0, 3'd1);
        passo_ck("rs_bo5", 0, 2'b00, 1, 0, 0, 3'd2);
        passo_ck("rs_bo6", 0, 2'b00, 1, 0, 0, 3'd2);
        passo_ck("rs_reset", 0, 2'b00, 1, 1, 1, 3'd0);
        passo_ck("rs_idle", 0, 2'b00, 1, 0, 0, 3'd0);
        passo_ck("fr_start", 1, 2'b01, 1, 0, 0, 3'd1);
        for (int i = 0; i < 3; i++) passo_ck("fr_aq", 0, 2'b00, 1, 0, 0, 3'd1);
        for (int i = 0; i < 3; i++) passo_ck("fr_bo", 0, 2'b00, 1, 0, 0, 3'd2);
        passo_ck("fr_done", 0, 2'b00, 1, 0, 0, 3'd3);
        passo_ck("fr_idle", 0, 2'b00, 1, 0, 0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
